// File: rtl/gray_code_pipe_pkg.sv
// gray_code_pipe_pkg: shared mode encoding and constants for the gray code pipeline
package gray_code_pipe_pkg;
  typedef enum logic [1:0] {
    BIN2GRAY = 2'b00,
    GRAY2BIN = 2'b01,
    BCD2GRAY = 2'b10,
    PASS     = 2'b11
  } mode_t;
  localparam logic [3:0] BCD_BAD_NIBBLE = 4'hF;
endpackage

// File: rtl/gray_code_pipe_bcd_digit_gray.sv
// bcd_digit_gray: converts one BCD digit to Gray code; digits above 9 map to BCD_BAD_NIBBLE with err set
// Ports: nib (BCD digit in), gray (Gray nibble out), err (digit was not valid BCD)
module bcd_digit_gray
  import gray_code_pipe_pkg::*;
(
  input  logic [3:0] nib,
  output logic [3:0] gray,
  output logic       err
);
  assign err  = nib > 4'd9;
  assign gray = err ? BCD_BAD_NIBBLE : nib ^ (nib >> 1);
endmodule

// File: rtl/gray_code_pipe.sv
// gray_code_pipe: two-stage valid/ready pipeline converting words between binary, Gray and BCD codes
// Ports: clk, rst (async active-high); in_valid/in_ready/in_data/in_mode upstream handshake;
//        out_valid/out_ready/out_data/out_mode/out_bcd_err downstream handshake;
//        err_cnt saturating count of delivered words flagged with out_bcd_err
module gray_code_pipe
  import gray_code_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic             out_bcd_err,
  output logic [CNT_W-1:0] err_cnt
);
  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  mode_t            s1_mode;
  logic             s2_load;
  logic [WIDTH-1:0] bcd_data;
  logic [WIDTH-1:0] g2b_data;
  logic [WIDTH-1:0] conv_data;
  logic [WIDTH/4-1:0] bcd_errs;
  logic             conv_err;
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || s2_load);
  for (genvar n = 0; n < WIDTH / 4; n++) begin : g_bcd
    bcd_digit_gray u_digit (
      .nib (s1_data[4*n+:4]),
      .gray(bcd_data[4*n+:4]),
      .err (bcd_errs[n])
    );
  end
  // Each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    g2b_data = '0;
    for (int i = 0; i < WIDTH; i++) g2b_data[i] = ^(s1_data >> i);
  end
  assign conv_data = s1_mode == BIN2GRAY ? s1_data ^ (s1_data >> 1) :
                     s1_mode == GRAY2BIN ? g2b_data :
                     s1_mode == BCD2GRAY ? bcd_data : s1_data;
  assign conv_err  = s1_mode == BCD2GRAY && |bcd_errs;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= BIN2GRAY;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      s1_data  <= in_data;
      s1_mode  <= mode_t'(in_mode);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_mode    <= 2'b00;
      out_bcd_err <= 1'b0;
    end else if (s2_load) begin
      out_valid   <= s1_valid;
      out_data    <= conv_data;
      out_mode    <= s1_mode;
      out_bcd_err <= conv_err;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt <= '0;
    else if (out_valid && out_ready && out_bcd_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
  end
endmodule
